// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multi-cycle MIPS-style control unit.
package mips_ctrl_pkg;

  // Controller sequencing states
  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  // Instruction classes produced by decode and held for the rest of the instruction
  typedef enum logic [3:0] {
    C_ALU_REG = 4'd0,
    C_ALU_IMM = 4'd1,
    C_SHIFT   = 4'd2,
    C_LOAD    = 4'd3,
    C_STORE   = 4'd4,
    C_BRANCH  = 4'd5,
    C_JMP     = 4'd6,
    C_JSB     = 4'd7,
    C_RET     = 4'd8,
    C_ILLEGAL = 4'd9
  } class_e;

  // Opcode patterns, each compared against the leading bits of the 6-bit opcode
  localparam logic [1:0] OP_ALU_REG = 2'b00;   // op[5:4]
  localparam logic [1:0] OP_ALU_IMM = 2'b01;   // op[5:4]
  localparam logic [2:0] OP_SHIFT   = 3'b110;  // op[5:3]
  localparam logic [2:0] OP_MEM     = 3'b100;  // op[5:3]
  localparam logic [1:0] OP_LD_SUB  = 2'b00;   // op[2:1] within OP_MEM
  localparam logic [1:0] OP_ST_SUB  = 2'b01;   // op[2:1] within OP_MEM
  localparam logic [2:0] OP_BRANCH  = 3'b101;  // op[5:3]
  localparam logic [3:0] OP_JUMP    = 4'b1110; // op[5:2], op[1] selects JSB
  localparam logic [5:0] OP_RET     = 6'b111100;

  // Branch condition encodings (op[2:1] of a branch)
  localparam logic [1:0] BR_Z  = 2'b00;
  localparam logic [1:0] BR_NZ = 2'b01;
  localparam logic [1:0] BR_C  = 2'b10;
  localparam logic [1:0] BR_NC = 2'b11;

  // PC source mux encodings
  localparam logic [1:0] PC_INC    = 2'b00;
  localparam logic [1:0] PC_TARGET = 2'b01;
  localparam logic [1:0] PC_STACK  = 2'b10;

  // Evaluate a branch condition against the ALU flags
  function automatic logic branch_taken(input logic [1:0] cond,
                                        input logic       zero,
                                        input logic       carry);
    logic taken;
    case (cond)
      BR_Z:    taken = zero;
      BR_NZ:   taken = ~zero;
      BR_C:    taken = carry;
      BR_NC:   taken = ~carry;
      default: taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/mips_decode.sv
// Combinational opcode decoder: instruction word -> class and operation fields.
module mips_decode
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_W = 19
) (
  input  logic [INSTR_W-1:0] instr,
  output class_e             iclass,
  output logic [2:0]         acode,
  output logic [1:0]         scode,
  output logic [1:0]         br_cond
);

  logic [5:0] op_s;
  logic       unused_operand_s;

  assign op_s    = instr[INSTR_W-1 -: 6];
  assign acode   = op_s[3:1];
  assign scode   = op_s[2:1];
  assign br_cond = op_s[2:1];

  // Operand bits are routed to the datapath directly; the decoder ignores them
  assign unused_operand_s = ^instr[INSTR_W-7:0];

  // Classify the opcode; anything not matching a known pattern is illegal
  always_comb begin
    iclass = C_ILLEGAL;
    if (op_s[5:4] == OP_ALU_REG) begin
      iclass = C_ALU_REG;
    end else if (op_s[5:4] == OP_ALU_IMM) begin
      iclass = C_ALU_IMM;
    end else if (op_s[5:3] == OP_SHIFT) begin
      iclass = C_SHIFT;
    end else if (op_s[5:3] == OP_MEM) begin
      if (op_s[2:1] == OP_LD_SUB) begin
        iclass = C_LOAD;
      end else if (op_s[2:1] == OP_ST_SUB) begin
        iclass = C_STORE;
      end else begin
        iclass = C_ILLEGAL;
      end
    end else if (op_s[5:3] == OP_BRANCH) begin
      iclass = C_BRANCH;
    end else if (op_s[5:2] == OP_JUMP) begin
      iclass = op_s[1] ? C_JSB : C_JMP;
    end else if (op_s == OP_RET) begin
      iclass = C_RET;
    end else begin
      iclass = C_ILLEGAL;
    end
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with
// return-stack occupancy tracking and sticky error flags.
module mips_mc_controller
  import mips_ctrl_pkg::*;
#(
  parameter int INSTR_W     = 19,
  parameter int STACK_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               instr_req,
  input  logic               instr_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic               zero,
  input  logic               carry,
  output logic               mem_req,
  input  logic               mem_ready,
  output logic               mem_read_write,
  output logic               reg2_read_source,
  output logic               alu_src,
  output logic               is_shift,
  output logic               mem_or_alu,
  output logic               reg_read_write,
  output logic [2:0]         acode,
  output logic [1:0]         scode,
  output logic               pc_write,
  output logic [1:0]         pc_src,
  output logic               stack_push,
  output logic               stack_pop,
  output logic               stack_err,
  output logic               illegal
);

  localparam int               OCC_W    = $clog2(STACK_DEPTH + 1);
  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(STACK_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ZERO = OCC_W'(0);
  localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [INSTR_W-1:0] ir_r;
  class_e             class_r;
  logic [OCC_W-1:0]   occ_r;
  logic               stack_err_r;
  logic               illegal_r;

  class_e             dec_class_s;
  logic [2:0]         dec_acode_s;
  logic [1:0]         dec_scode_s;
  logic [1:0]         dec_cond_s;

  logic               ir_load_s;
  logic               occ_inc_s;
  logic               occ_dec_s;
  logic               err_set_s;
  logic               ill_set_s;

  mips_decode #(
    .INSTR_W (INSTR_W)
  ) u_decode (
    .instr   (ir_r),
    .iclass  (dec_class_s),
    .acode   (dec_acode_s),
    .scode   (dec_scode_s),
    .br_cond (dec_cond_s)
  );

  // State, instruction register, class, occupancy and sticky flags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= S_FETCH;
      ir_r        <= {INSTR_W{1'b0}};
      class_r     <= C_ALU_REG;
      occ_r       <= OCC_ZERO;
      stack_err_r <= 1'b0;
      illegal_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (ir_load_s) begin
        ir_r <= instruction;
      end
      if (state_r == S_DECODE) begin
        class_r <= dec_class_s;
      end
      if (occ_inc_s) begin
        occ_r <= occ_r + OCC_ONE;
      end else if (occ_dec_s) begin
        occ_r <= occ_r - OCC_ONE;
      end
      stack_err_r <= stack_err_r | err_set_s;
      illegal_r   <= illegal_r | ill_set_s;
    end
  end

  // Next-state and output decode; reset forces every output low immediately
  always_comb begin
    state_nxt_s      = state_r;
    ir_load_s        = 1'b0;
    occ_inc_s        = 1'b0;
    occ_dec_s        = 1'b0;
    err_set_s        = 1'b0;
    ill_set_s        = 1'b0;
    instr_req        = 1'b0;
    mem_req          = 1'b0;
    mem_read_write   = 1'b0;
    reg2_read_source = 1'b0;
    alu_src          = 1'b0;
    is_shift         = 1'b0;
    mem_or_alu       = 1'b0;
    reg_read_write   = 1'b0;
    acode            = 3'b000;
    scode            = 2'b00;
    pc_write         = 1'b0;
    pc_src           = PC_INC;
    stack_push       = 1'b0;
    stack_pop        = 1'b0;
    stack_err        = 1'b0;
    illegal          = 1'b0;

    if (!rst_n) begin
      state_nxt_s = S_FETCH;
    end else begin
      stack_err = stack_err_r;
      illegal   = illegal_r;
      case (state_r)
        S_FETCH: begin
          instr_req = 1'b1;
          if (instr_valid) begin
            ir_load_s   = 1'b1;
            state_nxt_s = S_DECODE;
          end else begin
            state_nxt_s = S_FETCH;
          end
        end

        S_DECODE: begin
          state_nxt_s = S_EXEC;
        end

        S_EXEC: begin
          case (class_r)
            C_ALU_REG: begin
              acode       = dec_acode_s;
              mem_or_alu  = 1'b1;
              state_nxt_s = S_WB;
            end
            C_ALU_IMM: begin
              acode       = dec_acode_s;
              alu_src     = 1'b1;
              mem_or_alu  = 1'b1;
              state_nxt_s = S_WB;
            end
            C_SHIFT: begin
              scode       = dec_scode_s;
              is_shift    = 1'b1;
              mem_or_alu  = 1'b1;
              state_nxt_s = S_WB;
            end
            C_LOAD, C_STORE: begin
              reg2_read_source = 1'b1;
              alu_src          = 1'b1;
              state_nxt_s      = S_MEM;
            end
            C_BRANCH: begin
              pc_write    = 1'b1;
              pc_src      = branch_taken(dec_cond_s, zero, carry) ? PC_TARGET : PC_INC;
              state_nxt_s = S_FETCH;
            end
            C_JMP: begin
              pc_write    = 1'b1;
              pc_src      = PC_TARGET;
              state_nxt_s = S_FETCH;
            end
            C_JSB: begin
              pc_write    = 1'b1;
              state_nxt_s = S_FETCH;
              // A full stack turns the call into a plain fall-through
              if (occ_r == OCC_FULL) begin
                pc_src    = PC_INC;
                err_set_s = 1'b1;
              end else begin
                pc_src     = PC_TARGET;
                stack_push = 1'b1;
                occ_inc_s  = 1'b1;
              end
            end
            C_RET: begin
              pc_write    = 1'b1;
              state_nxt_s = S_FETCH;
              // An empty stack has no return address to use
              if (occ_r == OCC_ZERO) begin
                pc_src    = PC_INC;
                err_set_s = 1'b1;
              end else begin
                pc_src    = PC_STACK;
                stack_pop = 1'b1;
                occ_dec_s = 1'b1;
              end
            end
            default: begin
              ill_set_s   = 1'b1;
              pc_write    = 1'b1;
              pc_src      = PC_INC;
              state_nxt_s = S_FETCH;
            end
          endcase
        end

        S_MEM: begin
          mem_req          = 1'b1;
          reg2_read_source = 1'b1;
          alu_src          = 1'b1;
          mem_read_write   = (class_r == C_STORE);
          if (mem_ready) begin
            if (class_r == C_LOAD) begin
              state_nxt_s = S_WB;
            end else begin
              pc_write    = 1'b1;
              pc_src      = PC_INC;
              state_nxt_s = S_FETCH;
            end
          end else begin
            state_nxt_s = S_MEM;
          end
        end

        S_WB: begin
          reg_read_write = 1'b1;
          pc_write       = 1'b1;
          pc_src         = PC_INC;
          state_nxt_s    = S_FETCH;
          // Keep the datapath selects that produced the result being written
          case (class_r)
            C_ALU_REG: begin
              acode      = dec_acode_s;
              mem_or_alu = 1'b1;
            end
            C_ALU_IMM: begin
              acode      = dec_acode_s;
              alu_src    = 1'b1;
              mem_or_alu = 1'b1;
            end
            C_SHIFT: begin
              scode      = dec_scode_s;
              is_shift   = 1'b1;
              mem_or_alu = 1'b1;
            end
            C_LOAD: begin
              alu_src    = 1'b1;
              mem_or_alu = 1'b0;
            end
            default: begin
              mem_or_alu = 1'b0;
            end
          endcase
        end

        default: begin
          state_nxt_s = S_FETCH;
        end
      endcase
    end
  end

endmodule
